pipe_ctrl: RTL

Parametrised pipeline stall/flush controller for the MIPS core. It generalises the fixed five-stage stall encoder to NSTAGE stages and adds:
- bubble generation;
- a sequenced exception/ERET flush with PC redirect;
- a stall watchdog and a stall-cycle counter.

It sits beside the pipeline registers and drives their hold/clear enables and the PC redirect mux.

---
 rtl/pipe_ctrl_pkg.sv | 19 +
 rtl/pipe_ctrl_wdog.sv | 47 ++++
 rtl/pipe_ctrl.sv | 111 +++++++++++
 3 files changed

// File: rtl/pipe_ctrl_pkg.sv
`default_nettype none
// ============================================================
// pipe_ctrl_pkg : stage indices and flush FSM encodings  (rev 1.0)
// ============================================================
package pipe_ctrl_pkg;

  localparam int STG_PC  = 0;
  localparam int STG_ID  = 2;
  localparam int STG_EX  = 3;
  localparam int STG_MEM = 4;

  typedef enum logic [1:0] {
    PC_IDLE  = 2'd0,
    PC_WAIT  = 2'd1,
    PC_FLUSH = 2'd2
  } pc_state_e;

endpackage
`default_nettype wire

// File: rtl/pipe_ctrl_wdog.sv
`default_nettype none
// ============================================================
// pipe_ctrl_wdog : stall watchdog and stall-cycle counter  (rev 1.0)
// ============================================================
module pipe_ctrl_wdog #(
  parameter int WDOG  = 1024,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall_any,
  output logic             timeout,
  output logic [CNT_W-1:0] stall_cycles
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      stall_cycles <= '0;
    else if (stall_any)
      stall_cycles <= stall_cycles + CNT_W'(1);
  end

  generate
    if (WDOG > 0) begin : g_wdog
      localparam int WD_W = $clog2(WDOG + 1);
      logic [WD_W-1:0] cnt;

      // Counter saturates at WDOG; the flag is sticky until reset.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          cnt     <= '0;
          timeout <= 1'b0;
        end else if (!stall_any) begin
          cnt <= '0;
        end else if (cnt != WD_W'(WDOG)) begin
          cnt <= cnt + WD_W'(1);
          if (cnt == WD_W'(WDOG - 1))
            timeout <= 1'b1;
        end
      end
    end else begin : g_no_wdog
      assign timeout = 1'b0;
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/pipe_ctrl.sv
`default_nettype none
// ============================================================
// pipe_ctrl : pipeline stall/bubble encoder and flush sequencer  (rev 1.0)
// ============================================================
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int NSTAGE = 5,
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 32,
  parameter int WDOG   = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NSTAGE-1:0] stall_req,
  input  logic              flush_req,
  input  logic [ADDR_W-1:0] flush_pc,
  output logic [NSTAGE-1:0] stall,
  output logic [NSTAGE-1:0] bubble,
  output logic [NSTAGE-1:0] flush,
  output logic              redirect_valid,
  output logic [ADDR_W-1:0] redirect_pc,
  output logic              flush_busy,
  output logic              wdog_timeout,
  output logic [CNT_W-1:0]  stall_cycles
);

  localparam int TOP = NSTAGE - 1;

  pc_state_e         state;
  logic [NSTAGE-1:0] therm;
  logic              in_flush;

  // A request from stage k holds every younger stage as well.
  always_comb begin : thermometer
    logic acc;
    acc   = 1'b0;
    therm = '0;
    for (int i = NSTAGE - 1; i >= 0; i--) begin
      acc      = acc | stall_req[i];
      therm[i] = acc;
    end
  end

  assign in_flush = (state == PC_FLUSH);
  assign stall    = in_flush ? '0 : therm;

  assign bubble[0] = 1'b0;
  generate
    for (genvar i = 1; i < NSTAGE; i++) begin : g_bubble
      assign bubble[i] = stall[i-1] & ~stall[i];
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= PC_IDLE;
      flush          <= '0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      flush_busy     <= 1'b0;
    end else begin
      flush          <= '0;
      redirect_valid <= 1'b0;
      case (state)
        PC_IDLE: begin
          if (flush_req) begin
            redirect_pc <= flush_pc;
            flush_busy  <= 1'b1;
            // Let the oldest stage finish its memory access before clearing it.
            if (stall_req[TOP]) begin
              state <= PC_WAIT;
            end else begin
              state          <= PC_FLUSH;
              flush          <= '1;
              redirect_valid <= 1'b1;
            end
          end
        end
        PC_WAIT: begin
          if (!stall_req[TOP]) begin
            state          <= PC_FLUSH;
            flush          <= '1;
            redirect_valid <= 1'b1;
          end
        end
        PC_FLUSH: begin
          state      <= PC_IDLE;
          flush_busy <= 1'b0;
        end
        default: begin
          state      <= PC_IDLE;
          flush_busy <= 1'b0;
        end
      endcase
    end
  end

  pipe_ctrl_wdog #(
    .WDOG  (WDOG),
    .CNT_W (CNT_W)
  ) u_wdog (
    .clk          (clk),
    .rst          (rst),
    .stall_any    (stall[STG_PC]),
    .timeout      (wdog_timeout),
    .stall_cycles (stall_cycles)
  );

endmodule
`default_nettype wire
